// File: rtl/ddr_calib_gate.sv
// Holds SoC AXI traffic off the DDR controller until calibration completes,
// answering early requests locally with an error response, then becomes a wire.
package ddr_calib_gate_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic              aw_valid;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic              w_last;
    logic              b_ready;
    logic              ar_valid;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              r_ready;
  } axi4_slave_in_type;

  typedef struct packed {
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic              b_user;
    logic              ar_ready;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_user;
  } axi4_slave_out_type;

  typedef enum logic [2:0] {
    ERR_IDLE = 3'd0,
    ERR_W    = 3'd1,
    ERR_B    = 3'd2,
    ERR_R    = 3'd3,
    PASS     = 3'd4
  } gate_state_t;
endpackage

// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits on ready, and a raised valid holds its payload until accepted.
module ddr_calib_gate
  import ddr_calib_gate_pkg::*;
#(
  parameter logic [1:0] ERR_RESP = 2'b10,
  parameter int         ERRCNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_init_calib_done,
  input  axi4_slave_in_type   i_xslvi,
  output axi4_slave_out_type  o_xslvo,
  output axi4_slave_in_type   o_ddri,
  input  axi4_slave_out_type  i_ddro,
  output logic                o_pass,
  output logic [ERRCNT_W-1:0] o_err_cnt,
  output gate_state_t         o_state
);

  gate_state_t         state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic                reject;
  logic                ar_rdy, aw_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ERR_IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      if (reject && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  // Readies drop during reset and once calibration is done, so no error
  // transaction can start in the cycle the gate commits to PASS.
  assign ar_rdy = !i_init_calib_done && !i_rst;
  assign aw_rdy = ar_rdy && !i_xslvi.ar_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    reject  = 1'b0;
    o_xslvo = '0;
    o_ddri  = '0;
    case (state_q)
      ERR_IDLE: begin
        o_xslvo.ar_ready = ar_rdy;
        o_xslvo.aw_ready = aw_rdy;
        if (i_xslvi.ar_valid && ar_rdy) begin
          reject  = 1'b1;
          id_d    = i_xslvi.ar_id;
          cnt_d   = i_xslvi.ar_len;
          state_d = ERR_R;
        end else if (i_xslvi.aw_valid && aw_rdy) begin
          reject  = 1'b1;
          id_d    = i_xslvi.aw_id;
          state_d = ERR_W;
        end else if (i_init_calib_done) begin
          state_d = PASS;
        end
      end
      ERR_R: begin
        o_xslvo.r_valid = 1'b1;
        o_xslvo.r_resp  = ERR_RESP;
        o_xslvo.r_id    = id_q;
        o_xslvo.r_last  = (cnt_q == 8'd0);
        if (i_xslvi.r_ready) begin
          if (cnt_q == 8'd0) state_d = ERR_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      ERR_W: begin
        o_xslvo.w_ready = 1'b1;
        if (i_xslvi.w_valid && i_xslvi.w_last) state_d = ERR_B;
      end
      ERR_B: begin
        o_xslvo.b_valid = 1'b1;
        o_xslvo.b_resp  = ERR_RESP;
        o_xslvo.b_id    = id_q;
        if (i_xslvi.b_ready) state_d = ERR_IDLE;
      end
      PASS: begin
        o_xslvo = i_ddro;
        o_ddri  = i_xslvi;
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  assign o_pass    = (state_q == PASS);
  assign o_err_cnt = err_cnt_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_ddr_calib_gate.sv
// Directed bench for ddr_calib_gate: error bursts before calibration,
// AR priority, counter saturation, reset abort and pass-through.
module tb_ddr_calib_gate;
  import ddr_calib_gate_pkg::*;

  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               calib;
  axi4_slave_in_type  xslvi;
  axi4_slave_out_type xslvo;
  axi4_slave_in_type  ddri;
  axi4_slave_out_type ddro;
  logic               pass;
  logic [CW-1:0]      err_cnt;
  gate_state_t        state;

  int n_vec = 0;
  int n_err = 0;

  ddr_calib_gate #(.ERR_RESP(2'b10), .ERRCNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_calib_done(calib),
    .i_xslvi(xslvi), .o_xslvo(xslvo), .o_ddri(ddri), .i_ddro(ddro),
    .o_pass(pass), .o_err_cnt(err_cnt), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; calib = 1'b0; xslvi = '0; ddro = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; calib = 1'b0; xslvi = '0; ddro = '0;
    step();
    n_vec++; if (state !== ERR_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", state, ERR_IDLE); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got=%b exp=0", pass); end
    n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
    n_vec++; if (xslvo.ar_ready !== 1'b0 || xslvo.aw_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b%b exp=00", xslvo.ar_ready, xslvo.aw_ready); end
    rst = 1'b0; #1;
    n_vec++; if (xslvo.ar_ready !== 1'b1) begin n_err++; $display("FAIL release_ar_ready got=%b exp=1", xslvo.ar_ready); end
  endtask

  task automatic test_read_reject();
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd3; xslvi.ar_len = 8'd3; xslvi.ar_addr = 32'h100;
    #1;
    n_vec++; if (xslvo.ar_ready !== 1'b1) begin n_err++; $display("FAIL rd_ar_ready got=%b exp=1", xslvo.ar_ready); end
    step();
    xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (xslvo.r_valid !== 1'b1 || xslvo.r_id !== 4'd3 || xslvo.r_resp !== 2'b10 ||
          xslvo.r_data !== '0 || xslvo.r_last !== (i == 3)) begin
        n_err++;
        $display("FAIL rd_beat%0d got v=%b id=%0d resp=%b last=%b exp v=1 id=3 resp=10 last=%b",
                 i, xslvo.r_valid, xslvo.r_id, xslvo.r_resp, xslvo.r_last, (i == 3));
      end
      if (i == 1) begin
        xslvi.r_ready = 1'b0;
        step();
        n_vec++; if (xslvo.r_valid !== 1'b1 || xslvo.r_last !== 1'b0) begin n_err++; $display("FAIL rd_stall got v=%b last=%b exp v=1 last=0", xslvo.r_valid, xslvo.r_last); end
        xslvi.r_ready = 1'b1;
      end
      n_vec++; if (ddri !== '0) begin n_err++; $display("FAIL rd_ddri_quiet got=%h exp=0", ddri); end
      step();
    end
    xslvi.r_ready = 1'b0;
    n_vec++; if (xslvo.r_valid !== 1'b0 || state !== ERR_IDLE) begin n_err++; $display("FAIL rd_done got v=%b st=%0d exp v=0 st=0", xslvo.r_valid, state); end
    n_vec++; if (err_cnt !== 4'd1) begin n_err++; $display("FAIL rd_cnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_write_reject();
    xslvi.w_valid = 1'b1; xslvi.w_data = 64'hdead;
    #1;
    n_vec++; if (xslvo.w_ready !== 1'b0) begin n_err++; $display("FAIL wr_early_w got=%b exp=0", xslvo.w_ready); end
    xslvi.aw_valid = 1'b1; xslvi.aw_id = 4'd5; xslvi.aw_len = 8'd1;
    #1;
    n_vec++; if (xslvo.aw_ready !== 1'b1) begin n_err++; $display("FAIL wr_aw_ready got=%b exp=1", xslvo.aw_ready); end
    step();
    xslvi.aw_valid = 1'b0;
    n_vec++; if (xslvo.w_ready !== 1'b1 || xslvo.b_valid !== 1'b0) begin n_err++; $display("FAIL wr_beat1 got wr=%b bv=%b exp wr=1 bv=0", xslvo.w_ready, xslvo.b_valid); end
    step();
    xslvi.w_last = 1'b1;
    n_vec++; if (xslvo.w_ready !== 1'b1 || ddri !== '0) begin n_err++; $display("FAIL wr_beat2 got wr=%b ddri=%h exp wr=1 ddri=0", xslvo.w_ready, ddri); end
    step();
    xslvi.w_valid = 1'b0; xslvi.w_last = 1'b0;
    n_vec++; if (xslvo.b_valid !== 1'b1 || xslvo.b_id !== 4'd5 || xslvo.b_resp !== 2'b10 || xslvo.w_ready !== 1'b0) begin
      n_err++; $display("FAIL wr_b got v=%b id=%0d resp=%b wr=%b exp v=1 id=5 resp=10 wr=0", xslvo.b_valid, xslvo.b_id, xslvo.b_resp, xslvo.w_ready);
    end
    step();
    n_vec++; if (xslvo.b_valid !== 1'b1) begin n_err++; $display("FAIL wr_b_hold got=%b exp=1", xslvo.b_valid); end
    xslvi.b_ready = 1'b1;
    step();
    xslvi.b_ready = 1'b0;
    n_vec++; if (xslvo.b_valid !== 1'b0 || state !== ERR_IDLE || err_cnt !== 4'd2) begin
      n_err++; $display("FAIL wr_done got bv=%b st=%0d cnt=%0d exp bv=0 st=0 cnt=2", xslvo.b_valid, state, err_cnt);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd1; xslvi.ar_len = 8'd0;
    xslvi.aw_valid = 1'b1; xslvi.aw_id = 4'd2;
    #1;
    n_vec++; if (xslvo.ar_ready !== 1'b1 || xslvo.aw_ready !== 1'b0) begin n_err++; $display("FAIL pri_ready got ar=%b aw=%b exp ar=1 aw=0", xslvo.ar_ready, xslvo.aw_ready); end
    step();
    xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
    n_vec++; if (xslvo.r_valid !== 1'b1 || xslvo.r_last !== 1'b1 || xslvo.r_id !== 4'd1) begin n_err++; $display("FAIL pri_r got v=%b last=%b id=%0d exp v=1 last=1 id=1", xslvo.r_valid, xslvo.r_last, xslvo.r_id); end
    step();
    xslvi.r_ready = 1'b0;
    n_vec++; if (xslvo.aw_ready !== 1'b1) begin n_err++; $display("FAIL pri_aw_next got=%b exp=1", xslvo.aw_ready); end
    step();
    xslvi.aw_valid = 1'b0; xslvi.w_valid = 1'b1; xslvi.w_last = 1'b1;
    step();
    xslvi.w_valid = 1'b0; xslvi.w_last = 1'b0; xslvi.b_ready = 1'b1;
    n_vec++; if (xslvo.b_valid !== 1'b1 || xslvo.b_id !== 4'd2) begin n_err++; $display("FAIL pri_b got v=%b id=%0d exp v=1 id=2", xslvo.b_valid, xslvo.b_id); end
    step();
    xslvi.b_ready = 1'b0;
    n_vec++; if (err_cnt !== 4'd2 || state !== ERR_IDLE) begin n_err++; $display("FAIL pri_cnt got cnt=%0d st=%0d exp cnt=2 st=0", err_cnt, state); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      xslvi.ar_valid = 1'b1; xslvi.ar_len = 8'd0; xslvi.ar_id = 4'(i);
      step();
      xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
      step();
      xslvi.r_ready = 1'b0;
      if (i == 9) begin
        n_vec++; if (err_cnt !== 4'd10) begin n_err++; $display("FAIL sat_mid got=%0d exp=10", err_cnt); end
      end
    end
    n_vec++; if (err_cnt !== 4'hf) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", err_cnt); end
  endtask

  task automatic test_len255();
    int beats = 0;
    int last_at = 0;
    apply_reset();
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd15; xslvi.ar_len = 8'd255;
    step();
    xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (xslvo.r_valid !== 1'b1) break;
      beats++;
      if (xslvo.r_last === 1'b1 && last_at == 0) last_at = beats;
      step();
    end
    xslvi.r_ready = 1'b0;
    n_vec++; if (beats != 256 || last_at != 256) begin n_err++; $display("FAIL len255 got beats=%0d last_at=%0d exp 256/256", beats, last_at); end
  endtask

  task automatic test_rst_mid_burst();
    apply_reset();
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd4; xslvi.ar_len = 8'd7;
    step();
    xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
    step();
    n_vec++; if (xslvo.r_valid !== 1'b1 || xslvo.r_last !== 1'b0) begin n_err++; $display("FAIL rstb_beat2 got v=%b last=%b exp v=1 last=0", xslvo.r_valid, xslvo.r_last); end
    rst = 1'b1;
    step();
    n_vec++; if (xslvo.r_valid !== 1'b0 || err_cnt !== '0 || state !== ERR_IDLE) begin
      n_err++; $display("FAIL rstb_abort got v=%b cnt=%0d st=%0d exp v=0 cnt=0 st=0", xslvo.r_valid, err_cnt, state);
    end
    rst = 1'b0; xslvi.r_ready = 1'b0;
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd7; xslvi.ar_len = 8'd0;
    #1;
    n_vec++; if (xslvo.ar_ready !== 1'b1) begin n_err++; $display("FAIL rstb_new_ar got=%b exp=1", xslvo.ar_ready); end
    step();
    xslvi.ar_valid = 1'b0;
    n_vec++; if (xslvo.r_valid !== 1'b1 || xslvo.r_id !== 4'd7 || xslvo.r_last !== 1'b1) begin n_err++; $display("FAIL rstb_new_r got v=%b id=%0d last=%b exp v=1 id=7 last=1", xslvo.r_valid, xslvo.r_id, xslvo.r_last); end
    xslvi.r_ready = 1'b1;
    step();
    xslvi.r_ready = 1'b0;
  endtask

  task automatic test_calib_pass();
    apply_reset();
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd6; xslvi.ar_len = 8'd2;
    step();
    xslvi.ar_valid = 1'b0; xslvi.r_ready = 1'b1;
    step();
    calib = 1'b1;
    for (int i = 1; i < 3; i++) begin
      n_vec++; if (xslvo.r_valid !== 1'b1 || xslvo.r_last !== (i == 2)) begin n_err++; $display("FAIL cal_beat%0d got v=%b last=%b exp v=1 last=%b", i, xslvo.r_valid, xslvo.r_last, (i == 2)); end
      step();
    end
    xslvi.r_ready = 1'b0;
    n_vec++; if (state !== ERR_IDLE || pass !== 1'b0 || xslvo.ar_ready !== 1'b0) begin
      n_err++; $display("FAIL cal_idle got st=%0d pass=%b ar_rdy=%b exp st=0 pass=0 ar_rdy=0", state, pass, xslvo.ar_ready);
    end
    step();
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL cal_pass got=%b exp=1", pass); end
    xslvi.ar_valid = 1'b1; xslvi.ar_id = 4'd9; xslvi.ar_addr = 32'h1234_5678; xslvi.ar_len = 8'd5;
    xslvi.w_data = 64'h0123_4567_89ab_cdef;
    ddro.r_valid = 1'b1; ddro.r_data = 64'hfeed_beef_0000_1111; ddro.r_id = 4'd9; ddro.ar_ready = 1'b1; ddro.r_user = 1'b1;
    #1;
    n_vec++; if (ddri !== xslvi || ddri.ar_addr !== 32'h1234_5678) begin n_err++; $display("FAIL pass_req got=%h exp=%h", ddri, xslvi); end
    n_vec++; if (xslvo !== ddro || xslvo.r_data !== 64'hfeed_beef_0000_1111) begin n_err++; $display("FAIL pass_rsp got=%h exp=%h", xslvo, ddro); end
    calib = 1'b0;
    step(); step();
    n_vec++; if (pass !== 1'b1 || ddri.ar_valid !== 1'b1) begin n_err++; $display("FAIL pass_sticky got pass=%b arv=%b exp 1/1", pass, ddri.ar_valid); end
    xslvi = '0; ddro = '0;
  endtask

  initial begin
    test_reset();
    test_read_reject();
    test_write_reject();
    test_priority();
    test_saturate();
    test_len255();
    test_rst_mid_burst();
    test_calib_pass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_calib_gate.md
DDR_CALIB_GATE -- requirements
Module: ddr_calib_gate

Interface
Parameters:
REQ-001 ERR_RESP, 2'b10, AXI response code returned for requests rejected before calibration completes (SLVERR).
REQ-002 ERRCNT_W, 16, width of the saturating rejected-transaction counter.

Ports:
REQ-003 i_clk  in  1  single clock; the DDR UI clock.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_init_calib_done  in  1  DDR calibration complete, synchronous to i_clk.
REQ-006 i_xslvi  in  axi4_slave_in_type  SoC-side AXI request.
REQ-007 o_xslvo  out  axi4_slave_out_type  SoC-side AXI response.
REQ-008 o_ddri  out  axi4_slave_in_type  request forwarded to the DDR controller.
REQ-009 i_ddro  in  axi4_slave_out_type  DDR controller response.
REQ-010 o_pass  out  1  high when the gate is in PASS state.
REQ-011 o_err_cnt  out  ERRCNT_W  count of rejected AR plus AW transactions.

Function
REQ-012 States SHALL be ERR_IDLE, ERR_W, ERR_B, ERR_R and PASS; the reset state SHALL be ERR_IDLE.
REQ-013 In PASS, o_ddri SHALL equal i_xslvi and o_xslvo SHALL equal i_ddro, combinationally, with zero added latency.
REQ-014 In every non-PASS state, all o_ddri valid and ready signals SHALL be 0 and all other o_ddri fields SHALL be 0.
REQ-015 ERR_IDLE -> PASS SHALL occur on the first clock edge where i_init_calib_done=1 and no AR or AW handshake occurs in that cycle.
REQ-016 PASS SHALL be sticky: a later deassertion of i_init_calib_done SHALL NOT leave PASS; only i_rst exits it.
REQ-017 In ERR_IDLE, ar_ready=1 and aw_ready=1 SHALL hold only while i_init_calib_done=0.
REQ-018 ERR_IDLE, AR priority: when ar_valid and aw_valid are both 1, only AR SHALL be accepted (aw_ready=0 in that cycle).
REQ-019 Accepting AR SHALL latch ar_id and len into an 8-bit beat counter, then enter ERR_R.
REQ-020 ERR_R SHALL drive r_valid=1, r_data=0, r_resp=ERR_RESP and r_id equal to the latched id.
REQ-021 ERR_R: r_last=1 exactly on beat len+1; each r_ready handshake decrements the counter.
REQ-022 ERR_R: the handshake with r_last=1 SHALL return the gate to ERR_IDLE; r_valid SHALL hold while r_ready=0.
REQ-023 Accepting AW SHALL latch aw_id and enter ERR_W.
REQ-024 ERR_W SHALL drive w_ready=1 and discard data; the w_valid handshake with w_last=1 SHALL enter ERR_B.
REQ-025 ERR_B SHALL drive b_valid=1, b_resp=ERR_RESP and b_id equal to the latched id until b_ready=1, then return to ERR_IDLE.
REQ-026 W beats arriving in ERR_IDLE before AW SHALL NOT be accepted (w_ready=0).
REQ-027 o_err_cnt SHALL increment by 1 on each AR or AW acceptance in ERR_IDLE and SHALL saturate at all-ones without wrapping.
REQ-028 A len of 255 SHALL produce exactly 256 R beats.
REQ-029 All o_xslvo fields not listed for a state SHALL be 0, including r_user and b_user.

Reset
REQ-030 While i_rst=1, the state SHALL be ERR_IDLE, o_pass=0, o_err_cnt=0, the beat counter and latched id SHALL be 0, and all o_xslvo and o_ddri valid and ready signals SHALL be 0 except as REQ-017 allows after release.
REQ-031 Asserting i_rst mid-burst SHALL abort the burst immediately with no further R or B beats; after release, the gate SHALL be in ERR_IDLE.

Verification
REQ-032 Calib=0; AR id=3, len=3 -> 4 R beats, resp=2'b10, r_last on beat 4, id=3; o_err_cnt=1.
REQ-033 Calib=0; AW id=5 plus 2 W beats, the second with w_last -> single B with id=5, resp=2'b10; DDR side sees no valid.
REQ-034 Calib rises during ERR_R -> remaining R beats complete; PASS entered one cycle after return to ERR_IDLE; the next AR reaches o_ddri unchanged.
REQ-035 Simultaneous AR and AW in ERR_IDLE -> AR served first, then AW; o_err_cnt=2.
REQ-036 o_err_cnt preloaded near all-ones by 70k rejects (or reduced ERRCNT_W=4, 20 rejects) -> counter holds at all-ones.
REQ-037 i_rst pulse at R beat 2 of len=7 -> r_valid=0 in the cycle following assertion; o_err_cnt=0; new AR accepted after release.
